// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential multiply/divide unit with architectural HI/LO.
//
// Executes mult, multu, div and divu iteratively:
//   - multiply: 32 cycles of radix-2 shift-add;
//   - divide: 32 cycles of restoring division;
//   - then one fix-up cycle that applies the signs and writes HI/LO together.
// mthi and mtlo write HI or LO directly in IDLE.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high
//   start  in   1   one-cycle request
//   op     in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi,
//                   101 mtlo, 11x reserved
//   a      in  32   operand rs
//   b      in  32   operand rt
//   busy   out  1   iterative operation in progress (registered)
//   done   out  1   one-cycle pulse after HI/LO were written by mult/div
//   hi     out 32   HI register
//   lo     out 32   LO register
//
// Build option: MULDIV_FAST_MULT_EN
//   When defined, mult/multu use a single-cycle multiplier:
//   HI/LO are written at the start edge, busy stays low, and done pulses
//   on the next cycle. Divide is unchanged.
module muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state;
   state_t      state_next;
   logic [4:0]  cnt;
   logic        accept_iter;

   // Iteration datapath: for multiply acc = {partial product, remaining
   // multiplier}; for divide acc = {partial remainder, dividend/quotient}.
   logic [63:0] acc;
   logic [31:0] opnd;
   logic        is_div;
   logic        neg_lo;
   logic        neg_hi;

   logic        signed_op;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] result;

   function automatic logic [31:0] abs32(input logic [31:0] x);
      // 0x80000000 maps onto itself, which is its correct unsigned magnitude.
      return x[31] ? (32'd0 - x) : x;
   endfunction

   function automatic logic [63:0] mul_step(input logic [63:0] acc_in,
                                            input logic [31:0] mcand);
      logic [32:0] sum;
      sum = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, mcand} : 33'd0);
      return {sum, acc_in[31:1]};
   endfunction

   function automatic logic [63:0] div_step(input logic [63:0] acc_in,
                                            input logic [31:0] divisor);
      logic [32:0] top;
      logic [32:0] trial;
      top   = acc_in[63:31];
      trial = top - {1'b0, divisor};
      // A set bit 32 means the trial went negative: restore (keep shift only).
      if (!trial[32])
         return {trial[31:0], acc_in[30:0], 1'b1};
      else
         return {acc_in[62:0], 1'b0};
   endfunction

   function automatic logic [63:0] fix_result(input logic [63:0] acc_in,
                                              input logic        div_op,
                                              input logic        n_lo,
                                              input logic        n_hi);
      logic [31:0] q;
      logic [31:0] r;
      if (div_op) begin
         q = n_lo ? (32'd0 - acc_in[31:0])  : acc_in[31:0];
         r = n_hi ? (32'd0 - acc_in[63:32]) : acc_in[63:32];
         return {r, q};
      end
      return n_lo ? (64'd0 - acc_in) : acc_in;
   endfunction

`ifdef MULDIV_FAST_MULT_EN
   function automatic logic [63:0] fast_product(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input logic        sgn);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      logic signed [63:0] p;
      sx = sgn ? $signed({{32{x[31]}}, x}) : $signed({32'd0, x});
      sy = sgn ? $signed({{32{y[31]}}, y}) : $signed({32'd0, y});
      p  = sx * sy;
      return p;
   endfunction
`endif

   assign signed_op = ~op[0];
   assign mag_a     = signed_op ? abs32(a) : a;
   assign mag_b     = signed_op ? abs32(b) : b;
   assign result    = fix_result(acc, is_div, neg_lo, neg_hi);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next  = state;
      accept_iter = 1'b0;
      case (state)
         IDLE: begin
            if (start && !op[2]) begin
`ifdef MULDIV_FAST_MULT_EN
               accept_iter = op[1];
`else
               accept_iter = 1'b1;
`endif
               if (accept_iter)
                  state_next = RUN;
            end
         end
         RUN: begin
            if (cnt == 5'd0)
               state_next = FIX;
         end
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi   <= 32'd0;
         lo   <= 32'd0;
         cnt  <= 5'd0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         busy <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  if (accept_iter)
                     cnt <= 5'd31;
`ifdef MULDIV_FAST_MULT_EN
                  if (op[2:1] == 2'b00) begin
                     {hi, lo} <= fast_product(a, b, signed_op);
                     done     <= 1'b1;
                  end
`endif
                  if (op == 3'b100)
                     hi <= a;
                  if (op == 3'b101)
                     lo <= a;
               end
            end
            RUN: cnt <= cnt - 5'd1;
            FIX: begin
               {hi, lo} <= result;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Operand capture and iteration. Divide by zero needs no special case:
   // - every trial subtract succeeds, so the quotient becomes all ones;
   // - the remainder becomes |a|, and the remainder sign restores a;
   // - only the quotient negation must be suppressed when b is zero.
   always_ff @(posedge clk) begin
      if (state == IDLE && accept_iter) begin
         acc    <= {32'd0, mag_a};
         opnd   <= mag_b;
         is_div <= op[1];
         neg_lo <= signed_op & (a[31] ^ b[31]) & (~op[1] | (b != 32'd0));
         neg_hi <= signed_op & op[1] & a[31];
      end else if (state == RUN) begin
         acc <= is_div ? div_step(acc, opnd) : mul_step(acc, opnd);
      end
   end

endmodule
